// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

endpackage

// File: rtl/decod3to8_en.sv
// Dataflow 3-to-8 decoder with enable; output is all-zero when disabled.
module decod3to8_en
    import arb_pkg::*;
(
    input  logic            i_en,
    input  logic [IDXW-1:0] i_idx,
    output logic [NREQ-1:0] o_dec
);

    assign o_dec = i_en ? (NREQ'(1) << i_idx) : '0;

endmodule

// File: rtl/rr_arb8_decod.sv
// Eight-way round-robin arbiter with request/hold/release sequencing,
// optional hold timeout and a one-hot grant bus from a 3-to-8 decoder.
module rr_arb8_decod
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam bit            TO_EN     = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_LAST = TO_EN ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] r_gnt_idx;
    logic            r_gnt_valid;

    state_t          w_nxt_state;
    logic [CW-1:0]   w_nxt_cnt;
    logic [IDXW-1:0] w_nxt_ptr;
    logic [IDXW-1:0] w_nxt_idx;
    logic            w_nxt_valid;
    logic            w_timeout;
    logic            w_hold_hit;

    logic [NREQ-1:0] w_rot;
    logic [IDXW-1:0] w_off;
    logic [IDXW-1:0] w_sel;

    // Rotate so that bit 0 of w_rot is requester r_ptr; lowest set bit wins.
    assign w_rot = (req >> r_ptr) | (req << (4'(NREQ) - {1'b0, r_ptr}));

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDXW'(i);
        end
    end

    assign w_sel = r_ptr + w_off;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_ptr   = r_ptr;
        w_nxt_idx   = r_gnt_idx;
        w_nxt_valid = r_gnt_valid;
        w_timeout   = 1'b0;
        w_hold_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_nxt_idx   = w_sel;
                    w_nxt_valid = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = GRANT;
                end
            end
            GRANT: begin
                w_nxt_cnt  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                w_hold_hit = TO_EN && (r_cnt == HOLD_LAST);
                w_timeout  = w_hold_hit;
                if (done || !req[r_gnt_idx] || w_hold_hit) begin
                    w_nxt_state = IDLE;
                    w_nxt_valid = 1'b0;
                    w_nxt_ptr   = r_gnt_idx + 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_ptr       <= w_nxt_ptr;
            r_gnt_idx   <= w_nxt_idx;
            r_gnt_valid <= w_nxt_valid;
        end
    end

    decod3to8_en u_decod (
        .i_en  (r_gnt_valid),
        .i_idx (r_gnt_idx),
        .o_dec (gnt)
    );

    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = w_timeout;

endmodule

// File: tb/tb_rr_arb8_decod.sv
// Directed bench for rr_arb8_decod with MAX_HOLD=4.
module tb_rr_arb8_decod;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int n_multi = 0;

    rr_arb8_decod #(.MAX_HOLD(4), .CW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(gnt) > 1) n_multi++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] idx);
        logic [7:0] one;
        one = 8'h01;
        check({tag, " gnt"},       gnt,       one << idx);
        check({tag, " gnt_idx"},   gnt_idx,   idx);
        check({tag, " gnt_valid"}, gnt_valid, 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " gnt"},       gnt,       8'h00);
        check({tag, " gnt_valid"}, gnt_valid, 1'b0);
        check({tag, " timeout"},   timeout,   1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq [9];
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Reset held with all requests pending
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        repeat (3) tick();
        chk_idle("reset");
        check("reset gnt_idx", gnt_idx, 3'd0);

        // Single request
        req = 8'h10;
        rst_n = 1'b1;
        tick();
        chk_grant("single", 3'd4);
        done = 1'b1;
        tick();
        chk_idle("single release");
        done = 1'b0;

        // ptr is now 5; grant 5 then reset mid-cycle
        req = 8'hFF;
        tick();
        chk_grant("pre-reset", 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        check("async reset gnt_idx", gnt_idx, 3'd0);
        tick();
        rst_n = 1'b1;

        // Fairness from ptr=0
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_grant($sformatf("rr%0d", i), seq[i]);
            done = 1'b1;
            tick();
            check($sformatf("rr%0d release", i), gnt_valid, 1'b0);
            done = 1'b0;
        end
        check("rr onehot", n_multi, 0);

        // Wrap and skip: grant 5 to set ptr=6, then req=05
        req = 8'h20;
        tick();
        chk_grant("wrap setup", 3'd5);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h05;
        tick();
        chk_grant("wrap first", 3'd0);
        done = 1'b1;
        tick();
        check("wrap release", gnt_valid, 1'b0);
        done = 1'b0;
        tick();
        chk_grant("wrap second", 3'd2);
        done = 1'b1;
        tick();
        done = 1'b0;

        // Timeout: ptr=3, req=08 held
        req = 8'h08;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_grant($sformatf("hold%0d", k), 3'd3);
            check($sformatf("hold%0d timeout", k), timeout, (k == 3) ? 1'b1 : 1'b0);
            if (k < 3) tick();
        end
        tick();
        chk_idle("timeout idle");
        tick();
        chk_grant("timeout regrant", 3'd3);
        check("regrant timeout", timeout, 1'b0);

        // Withdrawal: release 3, then requester 2 drops mid-grant
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h04;
        tick();
        chk_grant("withdraw grant", 3'd2);
        req = 8'h00;
        #1;
        check("withdraw cycle timeout", timeout, 1'b0);
        tick();
        chk_idle("withdraw release");

        // done coinciding with timeout cycle
        req = 8'h04;
        tick();
        chk_grant("coincide grant", 3'd2);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("coincide pre%0d timeout", k), timeout, 1'b0);
            tick();
        end
        check("coincide timeout", timeout, 1'b1);
        done = 1'b1;
        tick();
        chk_idle("coincide release");
        done = 1'b0;
        tick();
        chk_grant("coincide regrant", 3'd2);
        check("coincide regrant timeout", timeout, 1'b0);

        // done in IDLE is ignored
        req = 8'h00;
        done = 1'b1;
        tick();
        tick();
        chk_idle("idle done");
        done = 1'b0;
        check("final onehot", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
